// File: rtl/ariane_pkg.sv
// Branch-prediction types shared between the BHT, gshare and meta predictors.
package ariane_pkg;

    // Per-slot direction prediction handed to the frontend.
    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

    // One gshare pattern-history entry: valid flag plus 2-bit counter.
    typedef struct packed {
        logic       valid;
        logic [1:0] saturation_counter;
    } gshare_entry_t;

    // Default number of global history bits folded into the gshare index.
    localparam int unsigned GSHARE_HIST_LEN = 8;

endpackage

// File: rtl/config_pkg.sv
// Core configuration record shared by the frontend predictors.
package config_pkg;

    typedef struct packed {
        int unsigned VLEN;             // virtual address width
        int unsigned INSTR_PER_FETCH;  // instruction slots per fetch block
        bit          RVC;              // compressed instructions enabled
    } cva6_cfg_t;

    // Default configuration: 32-bit VA, two 16-bit slots per fetch, RVC on.
    localparam cva6_cfg_t cva6_cfg_empty = '{
        VLEN:            32,
        INSTR_PER_FETCH: 2,
        RVC:             1'b1
    };

endpackage

// File: rtl/gshare_bp_pkg.sv
// Helpers local to the gshare predictor: counter reset value and update rule.
package gshare_bp_pkg;

    // Weakly not-taken: a fresh entry flips to taken after one taken outcome.
    localparam logic [1:0] COUNTER_RESET = 2'b01;

    // Saturating 2-bit counter step toward the resolved outcome.
    function automatic logic [1:0] counter_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken && (cnt != 2'b11)) begin
            nxt = cnt + 2'b01;
        end else if (!taken && (cnt != 2'b00)) begin
            nxt = cnt - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/gshare_pht.sv
// gshare pattern-history table: one combinational row read for prediction and
// one read-modify-write port for resolved branches. Storage is flops so a flush
// can clear every entry in a single cycle.
module gshare_pht
    import ariane_pkg::*;
    import gshare_bp_pkg::*;
#(
    parameter int unsigned NR_ROWS = 512,
    parameter int unsigned NR_COLS = 2,
    parameter int unsigned ROW_W   = 9,
    parameter int unsigned COL_W   = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    // prediction read port
    input  logic [ROW_W-1:0]           rd_row_i,
    output gshare_entry_t [NR_COLS-1:0] rd_entries_o,
    // read-modify-write update port
    input  logic                       upd_en_i,
    input  logic [ROW_W-1:0]           upd_row_i,
    input  logic [COL_W-1:0]           upd_col_i,
    input  logic                       upd_taken_i,
    output gshare_entry_t              upd_old_o
);

    logic [NR_ROWS-1:0][NR_COLS-1:0]       valid_q;
    logic [NR_ROWS-1:0][NR_COLS-1:0][1:0]  cnt_q;

    // Prediction row: raw stored entries, no bypass from a same-cycle update.
    always_comb begin
        for (int c = 0; c < int'(NR_COLS); c++) begin
            rd_entries_o[c].valid              = valid_q[rd_row_i][c];
            rd_entries_o[c].saturation_counter = cnt_q[rd_row_i][c];
        end
    end

    // Pre-update entry; the correctness report is judged against this value.
    always_comb begin
        upd_old_o.valid              = valid_q[upd_row_i][upd_col_i];
        upd_old_o.saturation_counter = cnt_q[upd_row_i][upd_col_i];
    end

    // Flush/reset clears the whole table and wins over any update in the cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            valid_q <= '0;
            cnt_q   <= {(NR_ROWS * NR_COLS){COUNTER_RESET}};
        end else if (upd_en_i) begin
            valid_q[upd_row_i][upd_col_i] <= 1'b1;
            cnt_q[upd_row_i][upd_col_i]   <= counter_next(upd_old_o.saturation_counter, upd_taken_i);
        end
    end

endmodule

// File: rtl/gshare_bp.sv
// gshare direction predictor: PC bits XOR global history index a table of
// 2-bit counters. Holds the speculative global history register, repairs it on
// mispredicts and reports per-slot correctness to the meta predictor.
//
// Handshake: every *_valid_i input is a single-cycle strobe with no back-pressure;
// the predictor always accepts it at the rising edge where it is high.
// global_correct_valid_o is a one-cycle strobe that qualifies global_correct_o.
module gshare_bp
    import ariane_pkg::*;
    import gshare_bp_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg    = config_pkg::cva6_cfg_empty,
    parameter int unsigned           NR_ENTRIES = 1024,
    parameter int unsigned           HIST_LEN   = ariane_pkg::GSHARE_HIST_LEN
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        flush_bp_i,
    input  logic                                        debug_mode_i,
    input  logic [CVA6Cfg.VLEN-1:0]                     vpc_i,
    input  logic                                        spec_valid_i,
    input  logic                                        spec_taken_i,
    input  logic                                        upd_valid_i,
    input  logic [CVA6Cfg.VLEN-1:0]                     upd_pc_i,
    input  logic                                        upd_taken_i,
    input  logic [HIST_LEN-1:0]                         upd_ghr_i,
    input  logic                                        upd_mispredict_i,
    output bht_prediction_t [CVA6Cfg.INSTR_PER_FETCH-1:0] gshare_prediction_o,
    output logic [HIST_LEN-1:0]                         ghr_o,
    output logic [CVA6Cfg.INSTR_PER_FETCH-1:0]          global_correct_o,
    output logic                                        global_correct_valid_o
);

    // Geometry matches the meta predictor so both index the same PC bits.
    localparam int unsigned INSTR_PER_FETCH = CVA6Cfg.INSTR_PER_FETCH;
    localparam int unsigned OFFSET          = CVA6Cfg.RVC ? 1 : 2;
    localparam int unsigned NR_ROWS         = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned ROW_ADDR_BITS   = $clog2(INSTR_PER_FETCH);
    localparam int unsigned PREDICTION_BITS = $clog2(NR_ROWS) + OFFSET + ROW_ADDR_BITS;
    localparam int unsigned IDX_W           = $clog2(NR_ROWS);
    localparam int unsigned COL_W           = (ROW_ADDR_BITS > 0) ? ROW_ADDR_BITS : 1;

    logic [HIST_LEN-1:0]                     ghr_q;
    logic [HIST_LEN-1:0]                     ghr_spec;
    logic [HIST_LEN-1:0]                     ghr_repair;
    logic [IDX_W-1:0]                        ghr_ext;
    logic [IDX_W-1:0]                        upd_ghr_ext;
    logic [IDX_W-1:0]                        rd_row;
    logic [IDX_W-1:0]                        upd_row;
    logic [COL_W-1:0]                        upd_col;
    logic                                    upd_en;
    gshare_entry_t [INSTR_PER_FETCH-1:0]     rd_entries;
    gshare_entry_t                           upd_old;
    logic [INSTR_PER_FETCH-1:0]              correct_d;
    logic [INSTR_PER_FETCH-1:0]              correct_q;
    logic                                    correct_valid_q;
    logic                                    unused_bits;

    // Debug mode freezes every piece of predictor state.
    assign upd_en = upd_valid_i && !debug_mode_i;

    // Zero-extend both history sources up to the row-index width.
    always_comb begin
        ghr_ext                     = '0;
        ghr_ext[HIST_LEN-1:0]       = ghr_q;
        upd_ghr_ext                 = '0;
        upd_ghr_ext[HIST_LEN-1:0]   = upd_ghr_i;
    end

    // Prediction uses live history; update uses the snapshot taken at predict time.
    assign rd_row  = vpc_i[PREDICTION_BITS-1:ROW_ADDR_BITS+OFFSET] ^ ghr_ext;
    assign upd_row = upd_pc_i[PREDICTION_BITS-1:ROW_ADDR_BITS+OFFSET] ^ upd_ghr_ext;
    assign upd_col = CVA6Cfg.RVC ? upd_pc_i[OFFSET +: COL_W] : '0;

    gshare_pht #(
        .NR_ROWS (NR_ROWS),
        .NR_COLS (INSTR_PER_FETCH),
        .ROW_W   (IDX_W),
        .COL_W   (COL_W)
    ) i_pht (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_bp_i),
        .rd_row_i     (rd_row),
        .rd_entries_o (rd_entries),
        .upd_en_i     (upd_en),
        .upd_row_i    (upd_row),
        .upd_col_i    (upd_col),
        .upd_taken_i  (upd_taken_i),
        .upd_old_o    (upd_old)
    );

    // Zero-latency per-slot prediction straight from the table row.
    always_comb begin
        for (int i = 0; i < int'(INSTR_PER_FETCH); i++) begin
            gshare_prediction_o[i].valid = rd_entries[i].valid;
            gshare_prediction_o[i].taken = rd_entries[i].saturation_counter[1];
        end
    end

    // Candidate next histories: shift in the speculative or the resolved outcome.
    assign ghr_spec   = HIST_LEN'({ghr_q, spec_taken_i});
    assign ghr_repair = HIST_LEN'({upd_ghr_i, upd_taken_i});

    // History register: flush clears, repair beats the speculative shift.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_bp_i) begin
            ghr_q <= '0;
        end else if (!debug_mode_i) begin
            if (upd_valid_i && upd_mispredict_i) begin
                ghr_q <= ghr_repair;
            end else if (spec_valid_i) begin
                ghr_q <= ghr_spec;
            end
        end
    end

    assign ghr_o = ghr_q;

    // Correctness of the counter as it stood before this update, in its slot only.
    always_comb begin
        correct_d = '0;
        if (upd_en) begin
            correct_d[upd_col] = (upd_old.saturation_counter[1] == upd_taken_i);
        end
    end

    // Register the report so the meta predictor sees it one cycle after the update.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_bp_i) begin
            correct_q       <= '0;
            correct_valid_q <= 1'b0;
        end else begin
            correct_q       <= correct_d;
            correct_valid_q <= upd_en;
        end
    end

    assign global_correct_o       = correct_q;
    assign global_correct_valid_o = correct_valid_q;

    // PC bits outside the index window and counter LSBs are not needed here.
    assign unused_bits = ^{vpc_i, upd_pc_i, upd_old, rd_entries};

endmodule

// File: tb/tb_gshare_bp.sv
// Self-checking bench for gshare_bp with a behavioural model of the table,
// history register and correctness report.
module tb_gshare_bp;
    import ariane_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst, flush, dbg;
    logic                    spec_valid, spec_taken;
    logic                    upd_valid, upd_taken, upd_misp;
    logic [31:0]             vpc, upd_pc;
    logic [7:0]              upd_ghr;
    bht_prediction_t [1:0]   pred;
    logic [7:0]              ghr;
    logic [1:0]              corr;
    logic                    corr_valid;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: counters 0..3 and valid flags per (row, slot).
    int          m_cnt [512][2];
    bit          m_vld [512][2];
    int          m_ghr;
    bit          m_cv;
    logic [1:0]  m_corr;
    logic [1:0]  exp_q [$];

    gshare_bp dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .flush_bp_i             (flush),
        .debug_mode_i           (dbg),
        .vpc_i                  (vpc),
        .spec_valid_i           (spec_valid),
        .spec_taken_i           (spec_taken),
        .upd_valid_i            (upd_valid),
        .upd_pc_i               (upd_pc),
        .upd_taken_i            (upd_taken),
        .upd_ghr_i              (upd_ghr),
        .upd_mispredict_i       (upd_misp),
        .gshare_prediction_o    (pred),
        .ghr_o                  (ghr),
        .global_correct_o       (corr),
        .global_correct_valid_o (corr_valid)
    );

    always #5 clk = ~clk;

    // Row = PC word bits [10:2] xor history; slot = PC halfword bit 1.
    function automatic int row_of(input logic [31:0] pc, input int hist);
        return (int'(pc >> 2) & 511) ^ (hist & 255);
    endfunction

    function automatic int col_of(input logic [31:0] pc);
        return int'(pc >> 1) & 1;
    endfunction

    // Expected {slot1.valid, slot1.taken, slot0.valid, slot0.taken}.
    function automatic logic [3:0] exp_pred(input logic [31:0] pc);
        int r;
        r = row_of(pc, m_ghr);
        return {m_vld[r][1], m_cnt[r][1] >= 2, m_vld[r][0], m_cnt[r][0] >= 2};
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int r, c;
        if (rst || flush) begin
            for (int i = 0; i < 512; i++) begin
                for (int j = 0; j < 2; j++) begin
                    m_cnt[i][j] = 1;
                    m_vld[i][j] = 1'b0;
                end
            end
            m_ghr  = 0;
            m_cv   = 1'b0;
            m_corr = 2'b00;
        end else if (dbg) begin
            m_cv   = 1'b0;
            m_corr = 2'b00;
        end else begin
            m_cv   = upd_valid;
            m_corr = 2'b00;
            if (upd_valid) begin
                r = row_of(upd_pc, int'(upd_ghr));
                c = col_of(upd_pc);
                m_corr[c] = ((m_cnt[r][c] >= 2) == upd_taken);
                m_vld[r][c] = 1'b1;
                if (upd_taken) m_cnt[r][c] = (m_cnt[r][c] == 3) ? 3 : m_cnt[r][c] + 1;
                else           m_cnt[r][c] = (m_cnt[r][c] == 0) ? 0 : m_cnt[r][c] - 1;
            end
            if (upd_valid && upd_misp)
                m_ghr = ((int'(upd_ghr) << 1) | int'(upd_taken)) & 255;
            else if (spec_valid)
                m_ghr = ((m_ghr << 1) | int'(spec_taken)) & 255;
        end
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; dbg = 1'b0;
        spec_valid = 1'b0; spec_taken = 1'b0;
        upd_valid = 1'b0; upd_taken = 1'b0; upd_misp = 1'b0;
        upd_ghr = 8'h00; upd_pc = 32'h0;
    endtask

    // One clock: model consumes the driven inputs, DUT samples them, settle.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1; vpc = 32'h1000;
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (pred !== 4'b0000) begin n_errors++; $display("FAIL reset_pred got=%b exp=0000", pred); end
        n_checks++; if (ghr !== 8'h00) begin n_errors++; $display("FAIL reset_ghr got=%h exp=00", ghr); end
        n_checks++; if (corr_valid !== 1'b0) begin n_errors++; $display("FAIL reset_cv got=%b exp=0", corr_valid); end
        n_checks++; if (corr !== 2'b00) begin n_errors++; $display("FAIL reset_corr got=%b exp=00", corr); end
    endtask

    task automatic test_saturate();
        logic [2:0] exp_bits;
        exp_bits = 3'b110;  // reports 0,1,1 for counters 01,10,11 before update
        idle(); vpc = 32'h1000;
        for (int i = 0; i < 3; i++) begin
            upd_valid = 1'b1; upd_pc = 32'h1000; upd_taken = 1'b1; upd_ghr = 8'h00;
            tick();
            n_checks++; if (corr_valid !== 1'b1) begin n_errors++; $display("FAIL sat_cv[%0d] got=%b exp=1", i, corr_valid); end
            n_checks++; if (corr !== {1'b0, exp_bits[i]}) begin n_errors++; $display("FAIL sat_corr[%0d] got=%b exp=%b", i, corr, {1'b0, exp_bits[i]}); end
        end
        idle(); vpc = 32'h1000;
        #1;
        n_checks++; if (pred[0] !== 2'b11) begin n_errors++; $display("FAIL sat_pred got=%b exp=11", pred[0]); end
        n_checks++; if (pred !== exp_pred(vpc)) begin n_errors++; $display("FAIL sat_pred_model got=%b exp=%b", pred, exp_pred(vpc)); end
    endtask

    task automatic test_ghr();
        idle();
        upd_valid = 1'b1; upd_misp = 1'b1; upd_ghr = 8'h07; upd_taken = 1'b1;
        upd_pc = 32'h0002_0000 | ($urandom_range(0, 255) << 2);
        tick(); idle();
        n_checks++; if (ghr !== 8'h0F) begin n_errors++; $display("FAIL ghr_repair got=%h exp=0f", ghr); end
        spec_valid = 1'b1; spec_taken = 1'b1;
        tick(); idle();
        n_checks++; if (ghr !== 8'h1F) begin n_errors++; $display("FAIL ghr_spec got=%h exp=1f", ghr); end
        upd_valid = 1'b1; upd_misp = 1'b1; upd_ghr = 8'h07; upd_taken = 1'b1; upd_pc = 32'h0003_0000;
        tick(); idle();
        spec_valid = 1'b1; spec_taken = 1'b1;
        upd_valid = 1'b1; upd_misp = 1'b1; upd_ghr = 8'h03; upd_taken = 1'b0; upd_pc = 32'h0004_0000;
        tick(); idle();
        n_checks++; if (ghr !== 8'h06) begin n_errors++; $display("FAIL ghr_repair_wins got=%h exp=06", ghr); end
        n_checks++; if (int'(ghr) !== m_ghr) begin n_errors++; $display("FAIL ghr_model got=%h exp=%h", ghr, m_ghr); end
    endtask

    task automatic test_alias();
        int a_bits, h1, b_bits;
        logic [31:0] pc_a;
        idle(); flush = 1'b1; tick(); idle();
        for (int i = 0; i < 3; i++) begin
            spec_valid = 1'b1; spec_taken = 1'($urandom_range(0, 1));
            tick();
        end
        idle();
        a_bits = $urandom_range(0, 511);
        h1     = $urandom_range(0, 255);
        pc_a   = 32'h8000_0000 | (a_bits << 2);
        for (int i = 0; i < 2; i++) begin
            upd_valid = 1'b1; upd_pc = pc_a; upd_taken = 1'b1; upd_ghr = 8'(h1);
            tick();
        end
        idle();
        b_bits = a_bits ^ h1 ^ m_ghr;
        vpc = 32'h4000_0000 | (b_bits << 2);
        #1;
        n_checks++; if (pred[0] !== 2'b11) begin n_errors++; $display("FAIL alias_slot0 got=%b exp=11", pred[0]); end
        n_checks++; if (pred[1].valid !== 1'b0) begin n_errors++; $display("FAIL alias_slot1 got=%b exp=0", pred[1].valid); end
        n_checks++; if (pred !== exp_pred(vpc)) begin n_errors++; $display("FAIL alias_model got=%b exp=%b", pred, exp_pred(vpc)); end
    endtask

    task automatic test_debug();
        int ghr_before;
        logic [3:0] pred_before;
        idle();
        upd_pc = 32'h0000_6000 | ($urandom_range(0, 63) << 2);
        vpc = upd_pc;
        ghr_before  = m_ghr;
        pred_before = exp_pred(vpc);
        dbg = 1'b1; upd_valid = 1'b1; upd_taken = 1'b1; upd_misp = 1'b1;
        upd_ghr = 8'(m_ghr ^ 8'h5A); spec_valid = 1'b1; spec_taken = 1'b1;
        tick();
        upd_ghr = 8'(m_ghr);
        #1;
        n_checks++; if (corr_valid !== 1'b0) begin n_errors++; $display("FAIL dbg_cv got=%b exp=0", corr_valid); end
        n_checks++; if (int'(ghr) !== ghr_before) begin n_errors++; $display("FAIL dbg_ghr got=%h exp=%h", ghr, ghr_before); end
        n_checks++; if (pred !== pred_before) begin n_errors++; $display("FAIL dbg_pred got=%b exp=%b", pred, pred_before); end
        idle();
    endtask

    task automatic test_flush();
        idle();
        upd_valid = 1'b1; upd_pc = 32'h2000; upd_taken = 1'b1; upd_ghr = 8'h00;
        tick(); idle();
        spec_valid = 1'b1; spec_taken = 1'b1; tick(); idle();
        flush = 1'b1; upd_valid = 1'b1; upd_pc = 32'h1000; upd_taken = 1'b1;
        upd_misp = 1'b1; upd_ghr = 8'h33; spec_valid = 1'b1; spec_taken = 1'b1;
        tick(); idle();
        vpc = 32'h2000;
        #1;
        n_checks++; if (ghr !== 8'h00) begin n_errors++; $display("FAIL flush_ghr got=%h exp=00", ghr); end
        n_checks++; if (corr_valid !== 1'b0) begin n_errors++; $display("FAIL flush_cv got=%b exp=0", corr_valid); end
        n_checks++; if (pred !== 4'b0000) begin n_errors++; $display("FAIL flush_pred2000 got=%b exp=0000", pred); end
        vpc = 32'h1000;
        #1;
        n_checks++; if (pred !== 4'b0000) begin n_errors++; $display("FAIL flush_pred1000 got=%b exp=0000", pred); end
        // A counter restored to 01 reports wrong on a taken outcome and then predicts taken.
        upd_valid = 1'b1; upd_pc = 32'h1000; upd_taken = 1'b1; upd_ghr = 8'h00;
        tick(); idle();
        n_checks++; if (corr !== 2'b00 || corr_valid !== 1'b1) begin n_errors++; $display("FAIL flush_cnt_corr got=%b/%b exp=00/1", corr, corr_valid); end
        #1;
        n_checks++; if (pred[0] !== 2'b11) begin n_errors++; $display("FAIL flush_cnt_pred got=%b exp=11", pred[0]); end
    endtask

    task automatic test_same_cycle();
        idle();
        vpc = 32'h3000 | 32'h2;
        upd_valid = 1'b1; upd_pc = 32'h3002; upd_taken = 1'b1; upd_ghr = 8'(m_ghr);
        #1;
        n_checks++; if (pred !== exp_pred(vpc) || pred[1].valid !== 1'b0) begin n_errors++; $display("FAIL same_cycle_old got=%b exp=%b", pred, exp_pred(vpc)); end
        tick(); idle();
        #1;
        n_checks++; if (pred[1] !== 2'b11) begin n_errors++; $display("FAIL same_cycle_new got=%b exp=11", pred[1]); end
        n_checks++; if (corr !== 2'b00 || corr_valid !== 1'b1) begin n_errors++; $display("FAIL same_cycle_corr got=%b/%b exp=00/1", corr, corr_valid); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_c;
        logic [31:0] pc;
        int g;
        idle();
        pc = 32'h5000 | ($urandom_range(0, 255) << 2) | (32'($urandom_range(0, 1)) << 1);
        g  = $urandom_range(0, 255);
        for (int i = 0; i < 8; i++) begin
            upd_valid = 1'b1; upd_pc = pc; upd_ghr = 8'(g); upd_taken = 1'((i < 4) ? 1 : (i & 1));
            tick();
            exp_q.push_back(m_corr);
            exp_c = exp_q.pop_front();
            n_checks++; if (corr !== exp_c || corr_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_corr[%0d] got=%b/%b exp=%b/1", i, corr, corr_valid, exp_c); end
        end
        idle();
        vpc = pc ^ ((32'(g) ^ 32'(m_ghr)) << 2);
        #1;
        n_checks++; if (pred !== exp_pred(vpc)) begin n_errors++; $display("FAIL b2b_pred got=%b exp=%b", pred, exp_pred(vpc)); end
    endtask

    task automatic test_reset_mid();
        idle();
        upd_valid = 1'b1; upd_pc = 32'h7004; upd_taken = 1'b1; upd_ghr = 8'h00;
        spec_valid = 1'b1; spec_taken = 1'b1;
        rst = 1'b1;
        tick(); idle();
        vpc = 32'h7004;
        #1;
        n_checks++; if (pred !== 4'b0000) begin n_errors++; $display("FAIL rst_mid_pred got=%b exp=0000", pred); end
        n_checks++; if (ghr !== 8'h00 || corr_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_state got=%h/%b exp=00/0", ghr, corr_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst        = 1'b0;
            flush      = ($urandom_range(0, 47) == 0);
            dbg        = ($urandom_range(0, 7) == 0);
            spec_valid = 1'($urandom_range(0, 1));
            spec_taken = 1'($urandom_range(0, 1));
            upd_valid  = 1'($urandom_range(0, 1));
            upd_taken  = ($urandom_range(0, 3) != 0);
            upd_misp   = ($urandom_range(0, 3) == 0);
            upd_pc     = 32'h1000 + (32'($urandom_range(0, 31)) << 1);
            upd_ghr    = 8'($urandom_range(0, 3));
            vpc        = 32'h1000 + (32'($urandom_range(0, 31)) << 1);
            #1;
            n_checks++; if (pred !== exp_pred(vpc)) begin n_errors++; $display("FAIL rnd_pred[%0d] got=%b exp=%b", i, pred, exp_pred(vpc)); end
            tick();
            n_checks++; if (int'(ghr) !== m_ghr) begin n_errors++; $display("FAIL rnd_ghr[%0d] got=%h exp=%h", i, ghr, m_ghr); end
            n_checks++; if (corr_valid !== m_cv || corr !== m_corr) begin n_errors++; $display("FAIL rnd_corr[%0d] got=%b/%b exp=%b/%b", i, corr, corr_valid, m_corr, m_cv); end
        end
        idle();
    endtask

    initial begin
        idle();
        vpc = 32'h0;
        test_reset();
        test_saturate();
        test_ghr();
        test_alias();
        test_debug();
        test_flush();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
